multdiv_sequencer: RTL

Iteration controller for the multdiv unit. It turns a one-cycle `ctrl_MULT` or `ctrl_DIV` request into the sequencing the datapath needs:
- an operand-load cycle;
- a fixed number of iteration-step cycles, counted by an internal 6-bit iteration counter;
- a one-cycle `data_resultRDY` pulse.

It sits between the pipeline's multdiv request signals and the multiplier/divider datapath registers. It owns all start, stop and done decisions for an operation.

---
 rtl/multdiv_sequencer_if.sv | 28 ++
 rtl/multdiv_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/multdiv_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multdiv_sequencer_if : request/sequencing bundle for multdiv_seq.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface multdiv_sequencer_if;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       init;
    logic       step;
    logic       op_div;
    logic [5:0] iter;
    logic       last;
    logic       busy;
    logic       data_resultRDY;

    // master issues requests (pipeline side); slave is the sequencer
    modport master (
        output ctrl_MULT, ctrl_DIV,
        input  init, step, op_div, iter, last, busy, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV,
        output init, step, op_div, iter, last, busy, data_resultRDY
    );
endinterface
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multdiv_sequencer : load / iterate / ready sequencing for multdiv. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module multdiv_sequencer #(
    parameter int ITER_MULT = 16,
    parameter int ITER_DIV  = 32
) (
    input  wire logic          clock,
    input  wire logic          reset,
    multdiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_MULT = 6'(ITER_MULT - 1);
    localparam logic [5:0] LAST_DIV  = 6'(ITER_DIV - 1);

    state_t     state;
    state_t     next_state;
    logic [5:0] count;
    logic       op_div_reg;
    logic       request;
    logic       at_last;

    logic       init_dec;
    logic       step_dec;
    logic [5:0] iter_dec;
    logic       last_dec;
    logic       busy_dec;
    logic       ready_dec;

    assign request = bus.ctrl_MULT | bus.ctrl_DIV;
    assign at_last = (count == (op_div_reg ? LAST_DIV : LAST_MULT));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counter is held at zero outside RUN, so LOAD always hands RUN a cleared count;
    // it stops at N-1 and therefore never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            op_div_reg <= 1'b0;
        end else begin
            if (request) begin
                op_div_reg <= bus.ctrl_DIV & ~bus.ctrl_MULT;
            end
            if (state == RUN && !at_last) begin
                count <= count + 6'd1;
            end else begin
                count <= '0;
            end
        end
    end

    // Outputs decode state only; requests influence next_state but never an output.
    always_comb begin
        next_state = state;
        init_dec   = 1'b0;
        step_dec   = 1'b0;
        iter_dec   = '0;
        last_dec   = 1'b0;
        busy_dec   = 1'b0;
        ready_dec  = 1'b0;
        case (state)
            IDLE: begin
                next_state = IDLE;
            end
            LOAD: begin
                init_dec   = 1'b1;
                busy_dec   = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                step_dec = 1'b1;
                busy_dec = 1'b1;
                iter_dec = count;
                last_dec = at_last;
                if (at_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                ready_dec  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // any request restarts, aborting whatever is in flight
        if (request) begin
            next_state = LOAD;
        end
    end

    assign bus.init           = init_dec;
    assign bus.step           = step_dec;
    assign bus.op_div         = op_div_reg;
    assign bus.iter           = iter_dec;
    assign bus.last           = last_dec;
    assign bus.busy           = busy_dec;
    assign bus.data_resultRDY = ready_dec;
endmodule
`default_nettype wire
